// File: rtl/pi2_mod_phase_stream.sv
// pi/2-BPSK / QPSK symbol-to-cyclic-phase mapper with one registered valid/ready stage.
// Optional per-frame phase offset enabled by defining PI2_MOD_PHASE_OFFSET_EN.
module pi2_mod_phase_stream #(
  parameter int unsigned CYC_DIV = 24,
  parameter int unsigned CNT_W   = 10,
  localparam int unsigned PW     = $clog2(CYC_DIV)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [1:0]       i_bits,
  input  logic             i_mode,
  input  logic             i_sof,
  input  logic             i_eof,
`ifdef PI2_MOD_PHASE_OFFSET_EN
  input  logic [PW-1:0]    i_phase_ofs,
`endif
  output logic             o_valid,
  input  logic             i_ready,
  output logic [PW-1:0]    o_phase,
  output logic             o_sof,
  output logic             o_eof,
  output logic [CNT_W-1:0] o_sym_cnt,
  output logic             o_err
);

  localparam int unsigned STEP = CYC_DIV / 8;
  localparam int unsigned SW   = PW + 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FRAME = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic               parity_q, parity_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               valid_q, valid_d;
  logic [PW-1:0]      phase_q, phase_d;
  logic               sof_q, sof_d;
  logic               eof_q, eof_d;
  logic [CNT_W-1:0]   sym_cnt_q, sym_cnt_d;
  logic               err_q, err_d;

  logic               accept;
  logic               eff_mode;
  logic               eff_par;
  logic [CNT_W-1:0]   eff_cnt;
  logic [1:0]         sym_idx;
  logic [2:0]         k_idx;
  logic [SW-1:0]      base_phase;
  logic [SW-1:0]      phase_full;

`ifdef PI2_MOD_PHASE_OFFSET_EN
  logic [PW-1:0]      ofs_q, ofs_d;
  logic [SW-1:0]      ofs_in_ext;
  logic [SW-1:0]      ofs_in_red;
  logic [PW-1:0]      eff_ofs;
  logic [SW-1:0]      phase_sum;
`endif

  assign o_ready = !valid_q | i_ready;
  assign accept  = i_valid & o_ready;

  // Effective per-beat context: an SOF beat restarts mode, parity and count.
  always_comb begin
    eff_mode = mode_q;
    eff_par  = parity_q;
    eff_cnt  = cnt_q;
    if (i_sof) begin
      eff_mode = i_mode;
      eff_par  = 1'b0;
      eff_cnt  = '0;
    end
  end

  // Odd octant k = 2*idx+1; QPSK idx is the Gray order 00,10,11,01 of {b0,b1}.
  always_comb begin
    sym_idx = {i_bits[0], eff_par};
    if (eff_mode) begin
      sym_idx = {i_bits[1], i_bits[0] ^ i_bits[1]};
    end
    k_idx      = {sym_idx, 1'b1};
    base_phase = SW'(32'(k_idx) * STEP);
  end

`ifdef PI2_MOD_PHASE_OFFSET_EN
  // Offset is reduced once on entry; the sum stays below 2*CYC_DIV so one subtract wraps it.
  always_comb begin
    ofs_in_ext = {1'b0, i_phase_ofs};
    ofs_in_red = ofs_in_ext;
    if (ofs_in_ext >= SW'(CYC_DIV)) begin
      ofs_in_red = ofs_in_ext - SW'(CYC_DIV);
    end
    eff_ofs = i_sof ? PW'(ofs_in_red) : ofs_q;
    ofs_d   = ofs_q;
    if (accept && i_sof) begin
      ofs_d = PW'(ofs_in_red);
    end
    phase_sum  = base_phase + {1'b0, eff_ofs};
    phase_full = phase_sum;
    if (phase_sum >= SW'(CYC_DIV)) begin
      phase_full = phase_sum - SW'(CYC_DIV);
    end
  end
`else
  assign phase_full = base_phase;
`endif

  // Frame tracking next-state and sticky out-of-frame error.
  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    if (accept) begin
      if (i_sof) begin
        state_d = i_eof ? ST_IDLE : ST_FRAME;
      end else begin
        if (state_q == ST_IDLE) begin
          err_d = 1'b1;
        end
        if (i_eof) begin
          state_d = ST_IDLE;
        end
      end
    end
  end

  // Symbol context and output stage updates.
  always_comb begin
    mode_d    = mode_q;
    parity_d  = parity_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    phase_d   = phase_q;
    sof_d     = sof_q;
    eof_d     = eof_q;
    sym_cnt_d = sym_cnt_q;
    if (o_ready) begin
      valid_d = i_valid;
    end
    if (accept) begin
      mode_d    = eff_mode;
      parity_d  = ~eff_par;
      cnt_d     = eff_cnt + CNT_W'(1);
      phase_d   = PW'(phase_full);
      sof_d     = i_sof;
      eof_d     = i_eof;
      sym_cnt_d = eff_cnt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode_q    <= 1'b0;
      parity_q  <= 1'b0;
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      phase_q   <= '0;
      sof_q     <= 1'b0;
      eof_q     <= 1'b0;
      sym_cnt_q <= '0;
      err_q     <= 1'b0;
    end else begin
      mode_q    <= mode_d;
      parity_q  <= parity_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      phase_q   <= phase_d;
      sof_q     <= sof_d;
      eof_q     <= eof_d;
      sym_cnt_q <= sym_cnt_d;
      err_q     <= err_d;
    end
  end

`ifdef PI2_MOD_PHASE_OFFSET_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ofs_q <= '0;
    end else begin
      ofs_q <= ofs_d;
    end
  end
`endif

  assign o_valid   = valid_q;
  assign o_phase   = phase_q;
  assign o_sof     = sof_q;
  assign o_eof     = eof_q;
  assign o_sym_cnt = sym_cnt_q;
  assign o_err     = err_q;

endmodule

// File: tb/tb_pi2_mod_phase_stream.sv
// Scoreboard bench for pi2_mod_phase_stream: directed frames pushed as expectations, a
// negedge monitor compares every presented output beat (including held beats under stall).
`timescale 1ns/1ps
module tb_pi2_mod_phase_stream;

  localparam int unsigned CYC_DIV = 24;
  localparam int unsigned CNT_W   = 10;
  localparam int unsigned PW      = $clog2(CYC_DIV);

  logic             i_clk = 1'b0;
  logic             i_rst_n = 1'b0;
  logic             i_valid = 1'b0;
  logic             o_ready;
  logic [1:0]       i_bits = 2'b00;
  logic             i_mode = 1'b0;
  logic             i_sof = 1'b0;
  logic             i_eof = 1'b0;
`ifdef PI2_MOD_PHASE_OFFSET_EN
  logic [PW-1:0]    i_phase_ofs = '0;
`endif
  logic             o_valid;
  logic             i_ready = 1'b1;
  logic [PW-1:0]    o_phase;
  logic             o_sof;
  logic             o_eof;
  logic [CNT_W-1:0] o_sym_cnt;
  logic             o_err;

  pi2_mod_phase_stream #(.CYC_DIV(CYC_DIV), .CNT_W(CNT_W)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_bits(i_bits), .i_mode(i_mode), .i_sof(i_sof), .i_eof(i_eof),
`ifdef PI2_MOD_PHASE_OFFSET_EN
    .i_phase_ofs(i_phase_ofs),
`endif
    .o_valid(o_valid), .i_ready(i_ready), .o_phase(o_phase), .o_sof(o_sof),
    .o_eof(o_eof), .o_sym_cnt(o_sym_cnt), .o_err(o_err)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int   phase;
    logic sof;
    logic eof;
    int   cnt;
    logic err;
    time  acc_t;
  } exp_t;

  exp_t sb_q[$];
  exp_t cur;
  bit   front_seen = 1'b0;
  int   n_checks = 0;
  int   n_errs = 0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Monitor: every presented beat must match the scoreboard head; popped on handshake.
  always @(negedge i_clk) begin
    if (i_rst_n && o_valid) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errs++;
        $display("FAIL unexpected_beat: got phase %0d cnt %0d expected no beat", o_phase, o_sym_cnt);
      end else begin
        cur = sb_q[0];
        if (!front_seen) chk("latency_ns", int'($time - cur.acc_t), 5);
        chk("phase", int'(o_phase), cur.phase);
        chk("sof", int'(o_sof), int'(cur.sof));
        chk("eof", int'(o_eof), int'(cur.eof));
        chk("sym_cnt", int'(o_sym_cnt), cur.cnt);
        chk("err", int'(o_err), int'(cur.err));
        if (i_ready) begin
          void'(sb_q.pop_front());
          front_seen = 1'b0;
        end else begin
          front_seen = 1'b1;
        end
      end
    end
  end

  // Called at a negedge; returns at the negedge after the beat is accepted.
  task automatic send(input logic [1:0] bits, input logic mode, input logic sof, input logic eof,
                      input int ph, input int cnt, input logic err);
    exp_t e;
    int   waited;
    waited  = 0;
    i_valid = 1'b1;
    i_bits  = bits;
    i_mode  = mode;
    i_sof   = sof;
    i_eof   = eof;
    while (!o_ready && waited < 100) begin
      @(negedge i_clk);
      waited++;
    end
    if (!o_ready) begin
      n_checks++;
      n_errs++;
      $display("FAIL send_timeout: got o_ready 0 expected 1 within 100 cycles");
      i_valid = 1'b0;
      return;
    end
    e.phase = ph;
    e.sof   = sof;
    e.eof   = eof;
    e.cnt   = cnt;
    e.err   = err;
    e.acc_t = $time + 5;
    sb_q.push_back(e);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    i_sof   = 1'b0;
    i_eof   = 1'b0;
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge i_clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #2;
    chk("rst_valid", int'(o_valid), 0);
    chk("rst_phase", int'(o_phase), 0);
    chk("rst_sof", int'(o_sof), 0);
    chk("rst_eof", int'(o_eof), 0);
    chk("rst_cnt", int'(o_sym_cnt), 0);
    chk("rst_err", int'(o_err), 0);
    chk("rst_ready", int'(o_ready), 1);
    idle(2);
    i_rst_n = 1'b1;
    idle(1);

    // BPSK frame bits 0,0,1,1,0
    send(2'd0, 1'b0, 1'b1, 1'b0,  3, 0, 1'b0);
    send(2'd0, 1'b0, 1'b0, 1'b0,  9, 1, 1'b0);
    send(2'd1, 1'b0, 1'b0, 1'b0, 15, 2, 1'b0);
    send(2'd1, 1'b0, 1'b0, 1'b0, 21, 3, 1'b0);
    send(2'd0, 1'b0, 1'b0, 1'b1,  3, 4, 1'b0);
    idle(2);

    // QPSK frame {b1,b0} = 00,01,11,10, then i_mode dropped mid-frame
    send(2'd0, 1'b1, 1'b1, 1'b0,  3, 0, 1'b0);
    send(2'd1, 1'b1, 1'b0, 1'b0,  9, 1, 1'b0);
    send(2'd3, 1'b1, 1'b0, 1'b0, 15, 2, 1'b0);
    send(2'd2, 1'b1, 1'b0, 1'b0, 21, 3, 1'b0);
    send(2'd0, 1'b0, 1'b0, 1'b0,  3, 4, 1'b0);
    send(2'd1, 1'b0, 1'b0, 1'b1,  9, 5, 1'b0);
    idle(1);

    // BPSK with input bubbles and a 3-cycle downstream stall
    fork
      begin
        send(2'd0, 1'b0, 1'b1, 1'b0, 3, 0, 1'b0);
        idle(1);
        send(2'd0, 1'b0, 1'b0, 1'b0, 9, 1, 1'b0);
        idle(2);
        send(2'd0, 1'b0, 1'b0, 1'b0, 3, 2, 1'b0);
        send(2'd0, 1'b0, 1'b0, 1'b1, 9, 3, 1'b0);
      end
      begin
        repeat (2) @(posedge i_clk);
        #1 i_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 i_ready = 1'b1;
      end
    join
    idle(2);

    // SOF restart inside a frame while parity is 1
    send(2'd1, 1'b0, 1'b1, 1'b0, 15, 0, 1'b0);
    send(2'd1, 1'b0, 1'b1, 1'b0, 15, 0, 1'b0);
    send(2'd1, 1'b0, 1'b0, 1'b1, 21, 1, 1'b0);
    idle(1);

    // Out-of-frame beat: mapped with held context (BPSK, parity 0, count 2), i_mode ignored
    send(2'd0, 1'b1, 1'b0, 1'b0,  3, 2, 1'b1);
    idle(1);
    send(2'd0, 1'b0, 1'b1, 1'b0,  3, 0, 1'b1);
    send(2'd1, 1'b0, 1'b0, 1'b1, 21, 1, 1'b1);
    idle(1);

`ifdef PI2_MOD_PHASE_OFFSET_EN
    // Offset latched on SOF only; out-of-range offset reduced mod CYC_DIV
    i_phase_ofs = PW'(20);
    send(2'd1, 1'b0, 1'b1, 1'b0, 11, 0, 1'b1);
    i_phase_ofs = PW'(0);
    send(2'd1, 1'b0, 1'b0, 1'b1, 17, 1, 1'b1);
    i_phase_ofs = PW'(30);
    send(2'd0, 1'b0, 1'b1, 1'b1,  9, 0, 1'b1);
    i_phase_ofs = PW'(0);
    idle(1);
`endif

    // Final beat then asynchronous reset while it is still presented
    send(2'd1, 1'b0, 1'b1, 1'b1, 15, 0, 1'b1);
    #2;
    chk("pre_reset_valid", int'(o_valid), 1);
    i_rst_n = 1'b0;
    #1;
    chk("arst_valid", int'(o_valid), 0);
    chk("arst_phase", int'(o_phase), 0);
    chk("arst_sof", int'(o_sof), 0);
    chk("arst_eof", int'(o_eof), 0);
    chk("arst_err", int'(o_err), 0);
    idle(2);
    i_rst_n = 1'b1;
    idle(3);
    chk("post_reset_err", int'(o_err), 0);
    chk("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

// File: doc/pi2_mod_phase_stream.md
Name: pi2_mod_phase_stream

Overview:
- Streaming constellation-to-phase mapper for PUCCH modulation.
- Accepts one symbol's bits per handshake and emits a cyclic phase index in units of 2*pi/CYC_DIV for the downstream cyclic-shift/rotation stage.
- Supports two modes, latched per frame: pi/2-BPSK, which tracks symbol-index parity internally, and QPSK.
- One registered pipeline stage with valid/ready backpressure; carries frame delimiters and a per-frame symbol counter.

Parameters:
CYC_DIV, 24, phase resolution (steps per full turn); must be a multiple of 8 and at most 256.
PW, $clog2(CYC_DIV), width of the phase index (derived; not overridden).
CNT_W, 10, width of the per-frame symbol counter.

Ports:
i_clk  input  1  clock
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  input symbol valid
o_ready  output  1  input accept; a beat transfers when i_valid & o_ready
i_bits  input  2  symbol bits; pi/2-BPSK uses i_bits[0] only; QPSK uses b0=i_bits[0], b1=i_bits[1]
i_mode  input  1  0 = pi/2-BPSK, 1 = QPSK; sampled only on an accepted SOF beat
i_sof  input  1  first symbol of frame
i_eof  input  1  last symbol of frame
o_valid  output  1  output valid
i_ready  input  1  downstream ready
o_phase  output  PW  phase index, range 0..CYC_DIV-1
o_sof  output  1  registered copy of i_sof
o_eof  output  1  registered copy of i_eof
o_sym_cnt  output  CNT_W  symbol index within the frame of the current output beat
o_err  output  1  sticky: a beat was accepted outside a frame (no prior SOF)

Behaviour:
- Reset (async, i_rst_n=0) sets:
  - o_valid=0, o_phase=0, o_sof=0, o_eof=0, o_sym_cnt=0, o_err=0.
  - Internal mode_q=0 (pi/2-BPSK), parity_q=0, cnt_q=0, in_frame_q=0.
- Handshake and latency:
  - o_ready = !o_valid | i_ready. There is no combinational path from i_valid to o_valid.
  - Latency is 1 cycle: an accepted beat appears on the outputs the next cycle.
  - Output registers hold while o_valid & !i_ready. Full throughput is one symbol per clock.
- Per accepted beat, define:
  - eff_mode = i_sof ? i_mode : mode_q
  - eff_par = i_sof ? 0 : parity_q
  - eff_cnt = i_sof ? 0 : cnt_q
- Phase index k (output o_phase = k*CYC_DIV/8, computed with a shift since CYC_DIV%8==0):
  - pi/2-BPSK, {b0, eff_par}: 00 gives k=1, 01 gives k=3, 10 gives k=5, 11 gives k=7.
  - QPSK, {b0, b1}: 00 gives k=1, 10 gives k=3, 11 gives k=5, 01 gives k=7.
- State updates on an accepted beat:
  - parity_q <= ~eff_par.
  - cnt_q <= eff_cnt+1, wrapping at 2^CNT_W.
  - o_sym_cnt <= eff_cnt.
  - mode_q <= eff_mode.
- Frame state machine, two states: IDLE (in_frame_q=0) and FRAME (in_frame_q=1).
  - IDLE to FRAME on an accepted beat with i_sof=1 and i_eof=0.
  - FRAME to IDLE on an accepted beat with i_eof=1.
  - A beat with i_sof=1 and i_eof=1 is a single-symbol frame; the state remains IDLE.
  - A beat with i_sof=1 accepted in FRAME restarts the frame: counter and parity reset for that beat, state stays FRAME, no error.
  - A beat accepted in IDLE with i_sof=0: o_err is set, sticky until reset. The beat is still mapped using the current mode_q/parity_q/cnt_q.
- While a frame is active, i_mode is ignored except on SOF beats.
- When i_valid=0, nothing advances: parity and counter hold across input bubbles and across backpressure.

Optional Feature:
- Macro: PI2_MOD_PHASE_OFFSET_EN.
- When defined:
  - Adds input port i_phase_ofs [PW-1:0], sampled on accepted SOF beats into ofs_q (reset 0).
  - The SOF beat itself uses the sampled i_phase_ofs value.
  - o_phase = (k*CYC_DIV/8 + ofs) mod CYC_DIV, computed without overflow at PW+1 bits.
  - i_phase_ofs >= CYC_DIV is reduced mod CYC_DIV.
- When undefined: the port is absent and no offset is applied.

Test Plan:
- Reset, CYC_DIV=24, BPSK frame, bits 0,0,1,1,0, SOF on first, EOF on last, i_ready=1:
  - o_phase 3,9,15,21,3.
  - o_sym_cnt 0..4.
  - o_sof on the first output only, o_eof on the last output only.
  - Each output one cycle after its input.
- QPSK frame, i_bits {b1,b0} = 00,01,11,10:
  - o_phase 3,9,15,21.
  - Then i_mode toggled mid-frame has no effect.
- BPSK stream with i_valid gaps and i_ready low for 3 cycles mid-frame:
  - o_phase/o_sym_cnt held stable while stalled.
  - Parity continues correctly: bits 0,0,0,0 give 3,9,3,9.
  - No beats dropped or duplicated.
- Beat with SOF inside an active frame at parity 1:
  - Output uses k from parity 0; o_sym_cnt=0.
- Beat without SOF after reset:
  - o_err rises and stays 1 through later valid frames until i_rst_n asserted.
- With PI2_MOD_PHASE_OFFSET_EN, i_phase_ofs=20 on SOF, BPSK bits 1,1:
  - o_phase (15+20)%24=11, then (21+20)%24=17.
- Optional addition to any scenario: assert i_rst_n low while o_valid=1; outputs clear immediately (async).
